// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier error monitor: default operand width and FSM encoding.
package mult_pkg;

    localparam int unsigned W_DEFAULT = 3;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StRun  = 2'd1;
    localparam state_t StDone = 2'd2;

endpackage

// File: rtl/abs_diff.sv
// Unsigned absolute difference of two 2W-bit products, plus an inequality flag.
module abs_diff
    import mult_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    output logic [2*W-1:0] ed,
    output logic           neq
);

    always_comb begin
        neq = (a != b);
        // Subtract in the order that cannot wrap.
        ed  = (a > b) ? (a - b) : (b - a);
    end

endmodule

// File: rtl/mult_error_monitor.sv
// Compares a multiplier's products against golden ones over a run of N_SAMPLES samples and
// reports mismatch count, summed and maximum absolute error through a 2-stage pipeline.
module mult_error_monitor
    import mult_pkg::*;
#(
    parameter int unsigned W         = W_DEFAULT,
    parameter int unsigned N_SAMPLES = 64,
    localparam int unsigned CW       = $clog2(N_SAMPLES + 1),
    localparam int unsigned SW       = 2 * W + CW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in_valid,
    input  logic [2*W-1:0]  y_dut,
    input  logic [2*W-1:0]  y_ref,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   err_count,
    output logic [SW-1:0]   sum_ed,
    output logic [2*W-1:0]  max_ed
);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           s1_valid_q, s1_valid_d;
    logic           s1_last_q, s1_last_d;
    logic           s1_neq_q, s1_neq_d;
    logic [2*W-1:0] s1_ed_q, s1_ed_d;
    logic           acc_last_q, acc_last_d;
    logic [CW-1:0]  err_q, err_d;
    logic [SW-1:0]  sum_q, sum_d;
    logic [2*W-1:0] max_q, max_d;

    logic [2*W-1:0] ed;
    logic           neq;
    logic           accept;
    logic           enter_run;

    abs_diff #(
        .W(W)
    ) u_abs_diff (
        .a  (y_dut),
        .b  (y_ref),
        .ed (ed),
        .neq(neq)
    );

    always_comb begin
        enter_run = start && (state_q != StRun);
        accept    = (state_q == StRun) && in_valid && (cnt_q < CW'(N_SAMPLES));

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (acc_last_q) state_d = StDone;
            StDone:  if (start) state_d = StRun;
            default: state_d = StIdle;
        endcase

        cnt_d = cnt_q;
        if (enter_run) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + CW'(1);
        end

        // Stage 1: capture the error of an accepted sample.
        s1_valid_d = accept;
        s1_last_d  = accept && (cnt_q == CW'(N_SAMPLES - 1));
        s1_ed_d    = accept ? ed : s1_ed_q;
        s1_neq_d   = accept ? neq : s1_neq_q;

        // Stage 2: accumulate; acc_last flags that the final sample has just landed.
        err_d      = err_q;
        sum_d      = sum_q;
        max_d      = max_q;
        acc_last_d = 1'b0;
        if (enter_run) begin
            err_d = '0;
            sum_d = '0;
            max_d = '0;
        end else if (s1_valid_q) begin
            err_d      = err_q + CW'(s1_neq_q);
            sum_d      = sum_q + SW'(s1_ed_q);
            max_d      = (s1_ed_q > max_q) ? s1_ed_q : max_q;
            acc_last_d = s1_last_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_ed_q    <= '0;
            s1_neq_q   <= 1'b0;
            acc_last_q <= 1'b0;
            err_q      <= '0;
            sum_q      <= '0;
            max_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_ed_q    <= s1_ed_d;
            s1_neq_q   <= s1_neq_d;
            acc_last_q <= acc_last_d;
            err_q      <= err_d;
            sum_q      <= sum_d;
            max_q      <= max_d;
        end
    end

    assign busy      = (state_q == StRun);
    assign done      = (state_q == StDone);
    assign err_count = err_q;
    assign sum_ed    = sum_q;
    assign max_ed    = max_q;

endmodule

// File: tb/tb_mult_error_monitor.sv
// Directed scoreboard bench for mult_error_monitor with W=3, N_SAMPLES=4.
module tb_mult_error_monitor;

    localparam int unsigned W  = 3;
    localparam int unsigned N  = 4;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned SW = 2 * W + CW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic [2*W-1:0]  y_dut = '0;
    logic [2*W-1:0]  y_ref = '0;
    logic            busy;
    logic            done;
    logic [CW-1:0]   err_count;
    logic [SW-1:0]   sum_ed;
    logic [2*W-1:0]  max_ed;

    mult_error_monitor #(
        .W        (W),
        .N_SAMPLES(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .y_dut    (y_dut),
        .y_ref    (y_ref),
        .busy     (busy),
        .done     (done),
        .err_count(err_count),
        .sum_ed   (sum_ed),
        .max_ed   (max_ed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        int s;
        int m;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model of the run in progress.
    bit   m_active = 0;
    int   m_cnt, m_err, m_sum, m_max;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_clear();
        m_active = 1;
        m_cnt = 0;
        m_err = 0;
        m_sum = 0;
        m_max = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_clear();
    endtask

    task automatic sample(input int d, input int r);
        int ed;
        in_valid = 1'b1;
        y_dut = (2 * W)'(d);
        y_ref = (2 * W)'(r);
        if (m_active && m_cnt < int'(N)) begin
            ed = (d > r) ? d - r : r - d;
            m_cnt++;
            if (d != r) m_err++;
            m_sum += ed;
            if (ed > m_max) m_max = ed;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.e = m_err;
        e.s = m_sum;
        e.m = m_max;
        exp_q.push_back(e);
        m_active = 0;
    endtask

    // Called on the negedge right after the last sample's accepting edge; lat<0 skips latency.
    task automatic wait_done(input string tag, input int lat);
        int   k;
        exp_t e;
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        if (lat >= 0) chk({tag, "_latency"}, 32'(k), 32'(lat));
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_err"}, 32'(err_count), 32'(e.e));
            chk({tag, "_sum"}, 32'(sum_ed), 32'(e.s));
            chk({tag, "_max"}, 32'(max_ed), 32'(e.m));
        end
    endtask

    initial begin
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_sum", 32'(sum_ed), 32'd0);
        chk("rst_max", 32'(max_ed), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        // Exact products
        do_start();
        chk("run_busy", 32'(busy), 32'd1);
        sample(0, 0);
        sample(9, 9);
        sample(36, 36);
        sample(49, 49);
        push_exp();
        wait_done("exact", 2);

        // Mixed errors, then hold in DONE while in_valid toggles
        do_start();
        sample(10, 9);
        sample(0, 4);
        sample(49, 49);
        sample(5, 5);
        push_exp();
        wait_done("mixed", 2);
        sample(63, 0);
        sample(7, 1);
        cyc(2);
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_err", 32'(err_count), 32'd2);
        chk("hold_sum", 32'(sum_ed), 32'd5);
        chk("hold_max", 32'(max_ed), 32'd4);

        // Gapped samples plus a dropped 5th
        do_start();
        sample(10, 9);
        cyc(3);
        sample(0, 4);
        cyc(3);
        sample(49, 49);
        cyc(3);
        sample(5, 5);
        sample(63, 0);
        push_exp();
        wait_done("gaps", -1);
        chk("gaps_err_abs", 32'(err_count), 32'd2);

        // Reset mid-run with a sample in flight
        do_start();
        sample(10, 9);
        sample(0, 4);
        m_active = 0;
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_err", 32'(err_count), 32'd0);
        chk("mid_rst_sum", 32'(sum_ed), 32'd0);
        chk("mid_rst_max", 32'(max_ed), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_sum", 32'(sum_ed), 32'd0);
        do_start();
        sample(0, 0);
        sample(9, 9);
        sample(36, 36);
        sample(49, 49);
        push_exp();
        wait_done("after_rst", 2);

        // Start held during RUN is ignored
        do_start();
        sample(10, 9);
        sample(0, 4);
        start = 1'b1;
        sample(49, 49);
        sample(5, 7);
        start = 1'b0;
        push_exp();
        wait_done("start_in_run", -1);

        // Start with in_valid in DONE: clears, sample not counted
        start = 1'b1;
        sample(63, 0);
        start = 1'b0;
        m_clear();
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_err", 32'(err_count), 32'd0);
        chk("restart_sum", 32'(sum_ed), 32'd0);
        chk("restart_max", 32'(max_ed), 32'd0);
        sample(1, 1);
        sample(4, 4);
        sample(9, 9);
        sample(16, 16);
        push_exp();
        wait_done("restart", 2);

        // Maximum error on every sample
        do_start();
        repeat (N) sample(63, 0);
        push_exp();
        wait_done("max", 2);
        chk("max_sum_abs", 32'(sum_ed), 32'd252);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
